// File: rtl/cevero_dvfs_actuator.sv
// Sequences DVFS operating-point changes: frequency drops before voltage drops, voltage rises before frequency rises.
// Transition latency depends on the step count. Requests arriving while busy are ignored and re-sampled in IDLE.
module cevero_dvfs_actuator #(
    parameter int MinVoltage    = 0,
    parameter int MaxVoltage    = 5,
    parameter int MinFreq       = 1,
    parameter int ResetVoltage  = 5,
    parameter int ResetFreq     = 7,
    parameter int VSettleCycles = 4,
    parameter int FLockCycles   = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] req_voltage_i,
    input  logic [2:0] req_freq_i,
    output logic [2:0] vreg_code_o,
    output logic [2:0] freq_code_o,
    output logic       clk_en_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        VSTEP   = 3'd2,
        VSETTLE = 3'd3,
        FSET    = 3'd4,
        FLOCK   = 3'd5,
        DONE    = 3'd6
    } state_e;

    localparam int WaitW = 8;

    state_e           state_q;
    logic [2:0]       tv_q;
    logic [2:0]       tf_q;
    logic [WaitW-1:0] wait_q;
    logic [2:0]       div_q;
    logic [2:0]       div_last;
    logic [2:0]       req_v_clamped;
    logic [2:0]       req_f_clamped;
    logic             flock_next;

    function automatic logic [2:0] clamp3(input logic [2:0] val, input int lo, input int hi);
        int v;
        v = int'(val);
        if (v < lo) begin
            v = lo;
        end else if (v > hi) begin
            v = hi;
        end
        return 3'(v);
    endfunction

    always_comb begin
        req_v_clamped = clamp3(req_voltage_i, MinVoltage, MaxVoltage);
        req_f_clamped = clamp3(req_freq_i, MinFreq, 7);
        div_last      = 3'd7 - freq_code_o;
        // The clock enable is registered, so it must look one state ahead to stay low through every FLOCK cycle.
        flock_next    = (state_q == FSET) || ((state_q == FLOCK) && (wait_q != '0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            tv_q        <= 3'(ResetVoltage);
            tf_q        <= 3'(ResetFreq);
            vreg_code_o <= 3'(ResetVoltage);
            freq_code_o <= 3'(ResetFreq);
            wait_q      <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            div_q       <= '0;
            clk_en_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((req_v_clamped != vreg_code_o) || (req_f_clamped != freq_code_o)) begin
                        tv_q    <= req_v_clamped;
                        tf_q    <= req_f_clamped;
                        state_q <= CHECK;
                        busy_o  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (tf_q < freq_code_o) begin
                        state_q <= FSET;
                    end else if (vreg_code_o != tv_q) begin
                        state_q <= VSTEP;
                    end else if (tf_q > freq_code_o) begin
                        state_q <= FSET;
                    end else begin
                        state_q <= DONE;
                        done_o  <= 1'b1;
                    end
                end
                VSTEP: begin
                    vreg_code_o <= (tv_q > vreg_code_o) ? vreg_code_o + 3'd1 : vreg_code_o - 3'd1;
                    wait_q      <= WaitW'(VSettleCycles - 1);
                    state_q     <= VSETTLE;
                end
                VSETTLE: begin
                    if (wait_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        wait_q <= wait_q - WaitW'(1);
                    end
                end
                FSET: begin
                    freq_code_o <= tf_q;
                    wait_q      <= WaitW'(FLockCycles - 1);
                    state_q     <= FLOCK;
                end
                FLOCK: begin
                    if (wait_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        wait_q <= wait_q - WaitW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase

            // Divider restarts on a frequency write so the new period begins cleanly after lock.
            if (state_q == FSET) begin
                div_q <= '0;
            end else if (div_q >= div_last) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 3'd1;
            end
            clk_en_o <= (div_q == '0) && !flock_next;
        end
    end

endmodule
